// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the pipelined MIPS core.
//
// A word-addressed on-chip RAM serves one request at a time after WAIT_CYCLES
// wait states. While a request is outstanding, stall is held to freeze the
// pipeline. A one-cycle resp_valid pulse, and read data for reads, follow one
// cycle after the access completes. Misaligned requests still complete with
// the normal timing, but they do not touch the RAM or rdata and they raise
// addr_err together with resp_valid.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-low reset
//   mem_en       in   request valid from the M stage
//   mem_write_en in   1 = write, 0 = read (ignored when mem_en=0)
//   byte_en      in   [3:0] write lanes, bit i -> wdata[8i+7:8i]
//   addr         in   [31:0] byte address; word index addr[ADDR_WIDTH+1:2]
//   wdata        in   [31:0] write data
//   rdata        out  [31:0] read data, held until the next good read
//   resp_valid   out  one-cycle completion pulse
//   addr_err     out  misalignment flag, coincident with resp_valid
//   stall        out  pipeline hold while the request is outstanding
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 0    // 0..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_write_en,
    input  logic [3:0]  byte_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        addr_err,
    output logic        stall
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0]  W_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nx;

    // Request copy captured on entry to WAIT; the ports are ignored afterwards.
    logic                  r_we;
    logic [3:0]            r_be;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [1:0]            r_lsb;
    logic [31:0]           r_wdata;

    logic [31:0]           r_mem [DEPTH];

    // Access actually performed at the end of this cycle.
    logic                  w_latch;
    logic                  w_go;
    logic                  w_we;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_lsb;
    logic [31:0]           w_wdata;
    logic                  w_misal;

    // Upper address bits are don't-care; accesses wrap modulo the RAM size.
    logic                  w_unused_addr_hi;
    assign w_unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next state, stall, and selection of the access source. With no wait
    // states, the access is taken straight from the ports in the request
    // cycle. Otherwise, it is taken from the latched copy in the last WAIT
    // cycle (cnt==1).
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_latch    = 1'b0;
        w_go       = 1'b0;
        stall      = 1'b0;
        w_we       = mem_write_en;
        w_be       = byte_en;
        w_idx      = addr[ADDR_WIDTH+1:2];
        w_lsb      = addr[1:0];
        w_wdata    = wdata;
        if (WAIT_CYCLES == 0) begin
            w_go = mem_en;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_en) begin
                        stall      = 1'b1;
                        w_latch    = 1'b1;
                        w_state_nx = S_WAIT;
                        w_cnt_nx   = W_LOAD;
                    end
                end
                S_WAIT: begin
                    w_we     = r_we;
                    w_be     = r_be;
                    w_idx    = r_idx;
                    w_lsb    = r_lsb;
                    w_wdata  = r_wdata;
                    w_cnt_nx = r_cnt - 4'd1;
                    if (r_cnt > 4'd1) begin
                        stall = 1'b1;
                    end else begin
                        w_go       = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
        if (!rst) begin
            stall = 1'b0;
        end
    end

    // Full-word accesses need a word-aligned address, and half-word lane
    // pairs need a half-word-aligned address. Every other lane pattern is
    // treated as aligned.
    always_comb begin
        w_misal = 1'b0;
        case (w_be)
            4'b1111:          w_misal = (w_lsb != 2'b00);
            4'b0011, 4'b1100: w_misal = w_lsb[0];
            default:          w_misal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_we    <= mem_write_en;
            r_be    <= byte_en;
            r_idx   <= addr[ADDR_WIDTH+1:2];
            r_lsb   <= addr[1:0];
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata      <= '0;
            resp_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            resp_valid <= w_go;
            addr_err   <= w_go & w_misal;
            if (w_go && !w_we && !w_misal) begin
                rdata <= r_mem[w_idx];
            end
        end
    end

    // RAM has no reset. A reset in the access cycle discards the write.
    always_ff @(posedge clk) begin
        if (rst && w_go && w_we && !w_misal) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] a;
        logic [31:0] d;
        logic        scr;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [3];
    logic        mem_en     [3];
    logic        mem_we     [3];
    logic [3:0]  be_i       [3];
    logic [31:0] addr_i     [3];
    logic [31:0] wdata_i    [3];
    logic [31:0] rdata      [3];
    logic        resp_valid [3];
    logic        addr_err   [3];
    logic        stall      [3];

    logic [31:0] mdl_mem [3][1024];
    logic [31:0] mdl_rd  [3];

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[0]), .mem_en(mem_en[0]), .mem_write_en(mem_we[0]),
        .byte_en(be_i[0]), .addr(addr_i[0]), .wdata(wdata_i[0]), .rdata(rdata[0]),
        .resp_valid(resp_valid[0]), .addr_err(addr_err[0]), .stall(stall[0]));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[1]), .mem_en(mem_en[1]), .mem_write_en(mem_we[1]),
        .byte_en(be_i[1]), .addr(addr_i[1]), .wdata(wdata_i[1]), .rdata(rdata[1]),
        .resp_valid(resp_valid[1]), .addr_err(addr_err[1]), .stall(stall[1]));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst[2]), .mem_en(mem_en[2]), .mem_write_en(mem_we[2]),
        .byte_en(be_i[2]), .addr(addr_i[2]), .wdata(wdata_i[2]), .rdata(rdata[2]),
        .resp_valid(resp_valid[2]), .addr_err(addr_err[2]), .stall(stall[2]));

    function automatic int wait_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    // Reference: a plain word array. A misaligned request changes nothing.
    // A good write merges the enabled bytes. A good read updates the
    // expected rdata.
    task automatic model_apply(input int k, input logic we, input logic [3:0] be,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic exp_err);
        int unsigned idx;
        logic [31:0] mask;
        idx     = (a >> 2) % 1024;
        exp_err = (be == 4'hF && a % 4 != 0) || ((be == 4'h3 || be == 4'hC) && a % 2 != 0);
        if (exp_err) return;
        if (we) begin
            mask = '0;
            for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
            mdl_mem[k][idx] = (mdl_mem[k][idx] & ~mask) | (d & mask);
        end else begin
            mdl_rd[k] = mdl_mem[k][idx];
        end
    endtask

    // Pipeline-like driver: holds the request while stall is seen and
    // optionally scrambles the ports during the stalled cycles. Returns the
    // observed response latency, number of stall cycles, addr_err, rdata, and
    // resp_valid one cycle later.
    task automatic run_req(input int k, input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d, input logic scramble,
                           output int lat, output int stalls, output logic err,
                           output logic [31:0] rd, output logic extra);
        logic released;
        logic s_now;
        lat = 99; stalls = 0; err = 1'bx; rd = 'x; extra = 1'bx; released = 1'b0;
        @(posedge clk); #1;
        mem_en[k] = 1'b1; mem_we[k] = we; be_i[k] = be; addr_i[k] = a; wdata_i[k] = d;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            s_now = stall[k];
            if (s_now) stalls++;
            if (resp_valid[k]) begin
                lat = c; err = addr_err[k]; rd = rdata[k];
                break;
            end
            @(posedge clk); #1;
            if (!released && !s_now) begin
                mem_en[k] = 1'b0;
                released  = 1'b1;
            end else if (!released && scramble) begin
                mem_we[k]  = 1'($urandom);
                be_i[k]    = 4'($urandom);
                addr_i[k]  = $urandom;
                wdata_i[k] = $urandom;
            end
        end
        mem_en[k] = 1'b0;
        if (lat != 99) begin
            @(negedge clk);
            extra = resp_valid[k];
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (stall[k] !== 1'b0) begin n_errors++; $display("FAIL reset stall[%0d] got=%b exp=0", k, stall[k]); end
            n_checks++; if (rdata[k] !== 32'h0) begin n_errors++; $display("FAIL reset rdata[%0d] got=%h exp=0", k, rdata[k]); end
            n_checks++; if (resp_valid[k] !== 1'b0) begin n_errors++; $display("FAIL reset resp_valid[%0d] got=%b exp=0", k, resp_valid[k]); end
            n_checks++; if (addr_err[k] !== 1'b0) begin n_errors++; $display("FAIL reset addr_err[%0d] got=%b exp=0", k, addr_err[k]); end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; mem_en[k] = 1'b0; mdl_rd[k] = '0;
        end
    endtask

    task automatic test_w0_basic();
        op_t ops [2];
        logic eerr, err, ext; int lat, stl; logic [31:0] rd;
        ops = '{'{1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0}, '{1'b0, 4'hF, 32'h10, 32'h0, 1'b0}};
        foreach (ops[i]) begin
            model_apply(0, ops[i].we, ops[i].be, ops[i].a, ops[i].d, eerr);
            run_req(0, ops[i].we, ops[i].be, ops[i].a, ops[i].d, ops[i].scr, lat, stl, err, rd, ext);
            n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL w0_basic[%0d] latency got=%0d exp=1", i, lat); end
            n_checks++; if (stl !== 0) begin n_errors++; $display("FAIL w0_basic[%0d] stall_cycles got=%0d exp=0", i, stl); end
            n_checks++; if (err !== eerr) begin n_errors++; $display("FAIL w0_basic[%0d] addr_err got=%b exp=%b", i, err, eerr); end
            n_checks++; if (rd !== mdl_rd[0]) begin n_errors++; $display("FAIL w0_basic[%0d] rdata got=%h exp=%h", i, rd, mdl_rd[0]); end
            n_checks++; if (ext !== 1'b0) begin n_errors++; $display("FAIL w0_basic[%0d] pulse_width got=%b exp=0", i, ext); end
        end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL w0_basic readback got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_wait_states();
        op_t ops [2];
        logic eerr, err, ext; int lat, stl; logic [31:0] rd;
        ops = '{'{1'b1, 4'hF, 32'h20, 32'h12345678, 1'b1}, '{1'b0, 4'hF, 32'h20, 32'h0, 1'b1}};
        foreach (ops[i]) begin
            model_apply(1, ops[i].we, ops[i].be, ops[i].a, ops[i].d, eerr);
            run_req(1, ops[i].we, ops[i].be, ops[i].a, ops[i].d, ops[i].scr, lat, stl, err, rd, ext);
            n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL wait3[%0d] latency got=%0d exp=4", i, lat); end
            n_checks++; if (stl !== 3) begin n_errors++; $display("FAIL wait3[%0d] stall_cycles got=%0d exp=3", i, stl); end
            n_checks++; if (err !== eerr) begin n_errors++; $display("FAIL wait3[%0d] addr_err got=%b exp=%b", i, err, eerr); end
            n_checks++; if (rd !== mdl_rd[1]) begin n_errors++; $display("FAIL wait3[%0d] rdata got=%h exp=%h", i, rd, mdl_rd[1]); end
            n_checks++; if (ext !== 1'b0) begin n_errors++; $display("FAIL wait3[%0d] pulse_width got=%b exp=0", i, ext); end
        end
        n_checks++; if (rd !== 32'h12345678) begin n_errors++; $display("FAIL wait3 readback got=%h exp=12345678", rd); end
    endtask

    task automatic test_byte_lanes();
        op_t ops [6];
        logic eerr, err, ext; int lat, stl; logic [31:0] rd;
        ops = '{'{1'b1, 4'hF, 32'h30, 32'h0, 1'b0},
                '{1'b1, 4'hF, 32'h30, 32'hAABBCCDD, 1'b0},
                '{1'b1, 4'h1, 32'h30, 32'h000000EE, 1'b0},
                '{1'b0, 4'h1, 32'h30, 32'h0, 1'b0},
                '{1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 1'b0},
                '{1'b0, 4'h0, 32'h30, 32'h0, 1'b0}};
        foreach (ops[i]) begin
            model_apply(0, ops[i].we, ops[i].be, ops[i].a, ops[i].d, eerr);
            run_req(0, ops[i].we, ops[i].be, ops[i].a, ops[i].d, ops[i].scr, lat, stl, err, rd, ext);
            n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL lanes[%0d] latency got=%0d exp=1", i, lat); end
            n_checks++; if (err !== eerr) begin n_errors++; $display("FAIL lanes[%0d] addr_err got=%b exp=%b", i, err, eerr); end
            n_checks++; if (rd !== mdl_rd[0]) begin n_errors++; $display("FAIL lanes[%0d] rdata got=%h exp=%h", i, rd, mdl_rd[0]); end
        end
        n_checks++; if (rd !== 32'hAABBCCEE) begin n_errors++; $display("FAIL lanes readback got=%h exp=aabbccee", rd); end
    endtask

    task automatic test_misaligned();
        op_t ops [9];
        logic eerr, err, ext; int lat, stl; logic [31:0] rd;
        ops = '{'{1'b1, 4'hF, 32'h40, 32'h11223344, 1'b0},
                '{1'b0, 4'hF, 32'h40, 32'h0, 1'b0},
                '{1'b1, 4'hF, 32'h42, 32'hCAFEF00D, 1'b0},
                '{1'b0, 4'hF, 32'h40, 32'h0, 1'b0},
                '{1'b1, 4'hF, 32'h44, 32'h55667788, 1'b0},
                '{1'b0, 4'hF, 32'h45, 32'h0, 1'b0},
                '{1'b1, 4'h3, 32'h41, 32'h0000FFFF, 1'b0},
                '{1'b1, 4'hC, 32'h46, 32'hABCD0000, 1'b0},
                '{1'b0, 4'h6, 32'h47, 32'h0, 1'b0}};
        foreach (ops[i]) begin
            model_apply(1, ops[i].we, ops[i].be, ops[i].a, ops[i].d, eerr);
            run_req(1, ops[i].we, ops[i].be, ops[i].a, ops[i].d, ops[i].scr, lat, stl, err, rd, ext);
            n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL misal[%0d] latency got=%0d exp=4", i, lat); end
            n_checks++; if (err !== eerr) begin n_errors++; $display("FAIL misal[%0d] addr_err got=%b exp=%b", i, err, eerr); end
            n_checks++; if (rd !== mdl_rd[1]) begin n_errors++; $display("FAIL misal[%0d] rdata got=%h exp=%h", i, rd, mdl_rd[1]); end
            n_checks++; if (ext !== 1'b0) begin n_errors++; $display("FAIL misal[%0d] pulse_width got=%b exp=0", i, ext); end
        end
        n_checks++; if (rd !== 32'hABCD7788) begin n_errors++; $display("FAIL misal readback got=%h exp=abcd7788", rd); end
    endtask

    task automatic test_wrap();
        op_t ops [2];
        logic eerr, err, ext; int lat, stl; logic [31:0] rd;
        ops = '{'{1'b1, 4'hF, 32'h1000, 32'h0BADCAFE, 1'b0}, '{1'b0, 4'hF, 32'h0000, 32'h0, 1'b0}};
        foreach (ops[i]) begin
            model_apply(0, ops[i].we, ops[i].be, ops[i].a, ops[i].d, eerr);
            run_req(0, ops[i].we, ops[i].be, ops[i].a, ops[i].d, ops[i].scr, lat, stl, err, rd, ext);
            n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL wrap[%0d] latency got=%0d exp=1", i, lat); end
        end
        n_checks++; if (rd !== 32'h0BADCAFE) begin n_errors++; $display("FAIL wrap readback got=%h exp=0badcafe", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic eerr, err, ext; int lat, stl; logic [31:0] rd;
        model_apply(2, 1'b1, 4'hF, 32'h50, 32'h0F0F0F0F, eerr);
        run_req(2, 1'b1, 4'hF, 32'h50, 32'h0F0F0F0F, 1'b0, lat, stl, err, rd, ext);
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL rstwait preload latency got=%0d exp=3", lat); end
        @(posedge clk); #1;
        mem_en[2] = 1'b1; mem_we[2] = 1'b1; be_i[2] = 4'hF; addr_i[2] = 32'h50; wdata_i[2] = 32'hFFFF0000;
        @(posedge clk); #1;
        rst[2] = 1'b0; mem_en[2] = 1'b0;
        @(negedge clk);
        n_checks++; if (stall[2] !== 1'b0) begin n_errors++; $display("FAIL rstwait stall_in_reset got=%b exp=0", stall[2]); end
        @(posedge clk); #1;
        rst[2] = 1'b1; mdl_rd[2] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (resp_valid[2] !== 1'b0) begin n_errors++; $display("FAIL rstwait resp_after_reset[%0d] got=%b exp=0", c, resp_valid[2]); end
            n_checks++; if (stall[2] !== 1'b0) begin n_errors++; $display("FAIL rstwait stall_after_reset[%0d] got=%b exp=0", c, stall[2]); end
        end
        n_checks++; if (rdata[2] !== 32'h0) begin n_errors++; $display("FAIL rstwait rdata got=%h exp=0", rdata[2]); end
        model_apply(2, 1'b0, 4'hF, 32'h50, 32'h0, eerr);
        run_req(2, 1'b0, 4'hF, 32'h50, 32'h0, 1'b0, lat, stl, err, rd, ext);
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL rstwait read latency got=%0d exp=3", lat); end
        n_checks++; if (rd !== 32'h0F0F0F0F) begin n_errors++; $display("FAIL rstwait old_value got=%h exp=0f0f0f0f", rd); end
    endtask

    task automatic test_back_to_back();
        logic eerr, ps; int stl, lat; logic [31:0] rd, exp_a, exp_b, prev;
        // W=3: the next request is presented in the cycle that resp_valid pulses.
        model_apply(1, 1'b0, 4'hF, 32'h20, 32'h0, eerr); exp_a = mdl_rd[1];
        model_apply(1, 1'b0, 4'hF, 32'h40, 32'h0, eerr); exp_b = mdl_rd[1];
        @(posedge clk); #1;
        mem_en[1] = 1'b1; mem_we[1] = 1'b0; be_i[1] = 4'hF; addr_i[1] = 32'h20;
        stl = 0;
        repeat (3) begin @(negedge clk); if (stall[1]) stl++; end
        n_checks++; if (stl !== 3) begin n_errors++; $display("FAIL b2b first stall_cycles got=%0d exp=3", stl); end
        @(negedge clk);
        n_checks++; if (stall[1] !== 1'b0) begin n_errors++; $display("FAIL b2b last_wait stall got=%b exp=0", stall[1]); end
        @(posedge clk); #1;
        addr_i[1] = 32'h40;
        @(negedge clk);
        n_checks++; if (resp_valid[1] !== 1'b1) begin n_errors++; $display("FAIL b2b first resp got=%b exp=1", resp_valid[1]); end
        n_checks++; if (rdata[1] !== exp_a) begin n_errors++; $display("FAIL b2b first rdata got=%h exp=%h", rdata[1], exp_a); end
        n_checks++; if (stall[1] !== 1'b1) begin n_errors++; $display("FAIL b2b second accepted stall got=%b exp=1", stall[1]); end
        ps = stall[1]; lat = 99; rd = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (!ps) mem_en[1] = 1'b0;
            @(negedge clk);
            if (resp_valid[1]) begin lat = c; rd = rdata[1]; break; end
            ps = stall[1];
        end
        mem_en[1] = 1'b0;
        n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL b2b second latency got=%0d exp=4", lat); end
        n_checks++; if (rd !== exp_b) begin n_errors++; $display("FAIL b2b second rdata got=%h exp=%h", rd, exp_b); end
        // W=0: a write followed the next cycle by a read of the same word.
        prev = mdl_rd[0];
        model_apply(0, 1'b1, 4'hF, 32'h60, 32'h600DF00D, eerr);
        model_apply(0, 1'b0, 4'hF, 32'h60, 32'h0, eerr);
        @(posedge clk); #1;
        mem_en[0] = 1'b1; mem_we[0] = 1'b1; be_i[0] = 4'hF; addr_i[0] = 32'h60; wdata_i[0] = 32'h600DF00D;
        @(posedge clk); #1;
        mem_we[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (resp_valid[0] !== 1'b1) begin n_errors++; $display("FAIL raw write resp got=%b exp=1", resp_valid[0]); end
        n_checks++; if (rdata[0] !== prev) begin n_errors++; $display("FAIL raw write rdata got=%h exp=%h", rdata[0], prev); end
        n_checks++; if (stall[0] !== 1'b0) begin n_errors++; $display("FAIL raw stall got=%b exp=0", stall[0]); end
        @(posedge clk); #1;
        mem_en[0] = 1'b0;
        @(negedge clk);
        n_checks++; if (resp_valid[0] !== 1'b1) begin n_errors++; $display("FAIL raw read resp got=%b exp=1", resp_valid[0]); end
        n_checks++; if (rdata[0] !== mdl_rd[0]) begin n_errors++; $display("FAIL raw read rdata got=%h exp=%h", rdata[0], mdl_rd[0]); end
        @(negedge clk);
        n_checks++; if (resp_valid[0] !== 1'b0) begin n_errors++; $display("FAIL raw idle resp got=%b exp=0", resp_valid[0]); end
    endtask

    task automatic test_random();
        int unsigned pool [8] = '{0, 1, 2, 3, 100, 511, 512, 1023};
        logic [3:0]  be_tab [10] = '{4'hF, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h6};
        logic eerr, err, ext, we, scr; int lat, stl; logic [31:0] rd, a, d; logic [3:0] be;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 33; n++) begin
                if (n < 8) begin
                    we = 1'b1; be = 4'hF; a = 32'(pool[n]) << 2; scr = 1'b0;
                end else begin
                    we  = 1'($urandom);
                    be  = be_tab[$urandom_range(0, 9)];
                    a   = ($urandom & 32'hFFFF_F000) | (32'(pool[$urandom_range(0, 7)]) << 2)
                          | 32'($urandom_range(0, 3));
                    scr = 1'($urandom);
                end
                d = $urandom;
                model_apply(k, we, be, a, d, eerr);
                run_req(k, we, be, a, d, scr, lat, stl, err, rd, ext);
                n_checks++; if (lat !== wait_of(k) + 1) begin n_errors++; $display("FAIL rand k%0d n%0d latency got=%0d exp=%0d", k, n, lat, wait_of(k) + 1); end
                n_checks++; if (stl !== wait_of(k)) begin n_errors++; $display("FAIL rand k%0d n%0d stall_cycles got=%0d exp=%0d", k, n, stl, wait_of(k)); end
                n_checks++; if (err !== eerr) begin n_errors++; $display("FAIL rand k%0d n%0d addr_err got=%b exp=%b", k, n, err, eerr); end
                n_checks++; if (rd !== mdl_rd[k]) begin n_errors++; $display("FAIL rand k%0d n%0d rdata got=%h exp=%h", k, n, rd, mdl_rd[k]); end
                n_checks++; if (ext !== 1'b0) begin n_errors++; $display("FAIL rand k%0d n%0d pulse_width got=%b exp=0", k, n, ext); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; mem_en[k] = 1'b1; mem_we[k] = 1'b0; be_i[k] = 4'hF;
            addr_i[k] = '0; wdata_i[k] = '0; mdl_rd[k] = '0;
        end
        test_reset();
        test_w0_basic();
        test_wait_states();
        test_byte_lanes();
        test_misaligned();
        test_wrap();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
